vme_cmd_sequencer: RTL

Simulation-side VME bus-master stage that consumes the command stream produced by the command file driver (`start`, `vme_cmd_reg`, `vme_dat_reg_in`) and executes each command as one single-word A24/D16 VME cycle against the ODMB VME slave. It returns completion data on `vme_dat_reg_out` with a one-cycle `vme_dat_wr` strobe, and paces the driver with `vme_cmd_rd`. It sits between the file driver and the DUT's VME pins in the top-level bench.

---
 rtl/vme_cmd_pkg.sv | 37 +++
 rtl/vme_sync2.sv | 27 ++
 rtl/vme_cmd_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/vme_cmd_pkg.sv
// Shared types and field positions for the VME command sequencer: FSM states,
// command/status bit positions and the default address modifier.
package vme_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_AS_ON,
    ST_DS_WAIT,
    ST_RELEASE,
    ST_DONE
  } state_t;

  localparam int READ_BIT  = 25;
  localparam int WRITE_BIT = 24;

  localparam int STAT_TIMEOUT_BIT = 16;
  localparam int STAT_READ_BIT    = 17;
  localparam int STAT_ILLEGAL_BIT = 18;

  localparam logic [5:0] DEFAULT_AM = 6'h39;

  // Completion word: read data in [15:0], status flags above, upper bits zero.
  function automatic logic [31:0] pack_result(input logic [15:0] data,
                                              input logic        timeout,
                                              input logic        is_read,
                                              input logic        illegal);
    logic [31:0] r;
    r                   = '0;
    r[15:0]             = data;
    r[STAT_TIMEOUT_BIT] = timeout;
    r[STAT_READ_BIT]    = is_read;
    r[STAT_ILLEGAL_BIT] = illegal;
    return r;
  endfunction

endpackage

// File: rtl/vme_sync2.sv
// Two-flop synchronizer for an asynchronous active-low bus strobe; resets to
// the inactive (high) level so a reset never looks like an acknowledge.
module vme_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so both flops sample
  // their inputs from before the edge; blocking here would collapse the chain
  // into a single flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/vme_cmd_sequencer.sv
// Bus-master stage turning driver commands into single A24/D16 VME cycles.
// Optional DTACK timeout is enabled by defining VME_CMD_TIMEOUT_EN.
module vme_cmd_sequencer
  import vme_cmd_pkg::*;
#(
  parameter int         SETUP_CYC   = 2,
  parameter int         TIMEOUT_CYC = 1023,
  parameter logic [5:0] VME_AM      = DEFAULT_AM
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] vme_cmd_reg,
  input  logic [31:0] vme_dat_reg_in,
  output logic        vme_cmd_rd,
  output logic        vme_dat_wr,
  output logic [31:0] vme_dat_reg_out,
  output logic [22:0] vme_addr,
  output logic [5:0]  vme_am,
  output logic        vme_as_b,
  output logic [1:0]  vme_ds_b,
  output logic        vme_write_b,
  output logic [15:0] vme_data_out,
  output logic        vme_data_oe,
  input  logic [15:0] vme_data_in,
  input  logic        vme_dtack_b
);

  state_t      state;
  logic [3:0]  setup_cnt;
  logic        is_read;
  logic        illegal;
  logic        timed_out;
  logic [15:0] cyc_data;
  logic        dtack_sync_b;

  logic cmd_read;
  logic cmd_write;

  // Read has priority: a command with both bits set runs as a read.
  assign cmd_read  = vme_cmd_reg[READ_BIT];
  assign cmd_write = vme_cmd_reg[WRITE_BIT] & ~vme_cmd_reg[READ_BIT];

  logic unused_inputs;
  assign unused_inputs = ^{vme_cmd_reg[31:26], vme_cmd_reg[0], vme_dat_reg_in[31:16]};

  vme_sync2 #(.RESET_VAL(1'b1)) u_dtack_sync (
    .clk (clk),
    .rst (rst),
    .d   (vme_dtack_b),
    .q   (dtack_sync_b)
  );

`ifdef VME_CMD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;
`else
  localparam int UNUSED_TIMEOUT_CYC = TIMEOUT_CYC;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      setup_cnt       <= '0;
      is_read         <= 1'b0;
      illegal         <= 1'b0;
      timed_out       <= 1'b0;
      cyc_data        <= '0;
      vme_cmd_rd      <= 1'b0;
      vme_dat_wr      <= 1'b0;
      vme_dat_reg_out <= '0;
      vme_addr        <= '0;
      vme_am          <= '0;
      vme_as_b        <= 1'b1;
      vme_ds_b        <= 2'b11;
      vme_write_b     <= 1'b1;
      vme_data_out    <= '0;
      vme_data_oe     <= 1'b0;
`ifdef VME_CMD_TIMEOUT_EN
      to_cnt          <= '0;
`endif
    end else begin
      vme_dat_wr <= 1'b0;

      case (state)
        ST_IDLE: begin
          // The ready flag rises one clock after entering IDLE, so a start held
          // high across the DONE pulse is never double-accepted.
          if (!vme_cmd_rd) begin
            vme_cmd_rd <= 1'b1;
          end else if (start) begin
            vme_cmd_rd <= 1'b0;
            is_read    <= cmd_read;
            illegal    <= ~cmd_read & ~cmd_write;
            timed_out  <= 1'b0;
            cyc_data   <= '0;
            setup_cnt  <= '0;
            state      <= ST_SETUP;
            if (cmd_read || cmd_write) begin
              vme_addr     <= vme_cmd_reg[23:1];
              vme_am       <= VME_AM;
              vme_write_b  <= cmd_read;
              vme_data_out <= cmd_write ? vme_dat_reg_in[15:0] : 16'h0000;
              vme_data_oe  <= cmd_write;
            end
          end
        end

        ST_SETUP: begin
          if (illegal) begin
            state <= ST_DONE;
          end else if (setup_cnt == 4'(SETUP_CYC - 1)) begin
            vme_as_b <= 1'b0;
            state    <= ST_AS_ON;
          end else begin
            setup_cnt <= setup_cnt + 4'd1;
          end
        end

        ST_AS_ON: begin
          vme_ds_b <= 2'b00;
          state    <= ST_DS_WAIT;
`ifdef VME_CMD_TIMEOUT_EN
          to_cnt   <= '0;
`endif
        end

        ST_DS_WAIT: begin
          if (!dtack_sync_b) begin
            if (is_read) cyc_data <= vme_data_in;
            vme_as_b    <= 1'b1;
            vme_ds_b    <= 2'b11;
            vme_data_oe <= 1'b0;
            state       <= ST_RELEASE;
          end
`ifdef VME_CMD_TIMEOUT_EN
          else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
            timed_out   <= 1'b1;
            vme_as_b    <= 1'b1;
            vme_ds_b    <= 2'b11;
            vme_data_oe <= 1'b0;
            state       <= ST_RELEASE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end

        ST_RELEASE: begin
          // After a timeout the slave may never release DTACK, so don't wait.
          if (dtack_sync_b || timed_out) state <= ST_DONE;
        end

        ST_DONE: begin
          vme_dat_wr      <= 1'b1;
          vme_dat_reg_out <= pack_result(cyc_data, timed_out, is_read, illegal);
          vme_write_b     <= 1'b1;
          state           <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
